// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU control path: opcodes, sequencer states
// and the control word that carries every datapath strobe.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_STA = 4'd4,
      OP_JMP = 4'd5,
      OP_JZ  = 4'd6,
      OP_OUT = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F0,
      S_F1,
      S_DEC,
      S_E0,
      S_E1,
      S_E2,
      S_HALT
   } ctrl_state_e;

   typedef struct packed {
      logic pc_inc;
      logic pc_load;
      logic mar_load;
      logic mar_sel_pc;
      logic mem_rd;
      logic mem_wr;
      logic ir_load;
      logic acc_load;
      logic acc_sel_alu;
      logic b_load;
      logic alu_sub;
      logic out_load;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decoder: maps the current sequencer state and latched
// opcode (plus zero_flag for conditional jumps) onto the datapath control word.
module cpu_ctrl_decode
   import cpu_pkg::*;
(
   input  ctrl_state_e i_state,
   input  opcode_e     i_op,
   input  logic        i_zero_flag,
   output ctrl_word_t  o_ctrl
);

   always_comb begin
      o_ctrl = CTRL_IDLE;
      case (i_state)
         S_F0: begin
            o_ctrl.mar_sel_pc = 1'b1;
            o_ctrl.mar_load   = 1'b1;
         end
         S_F1: begin
            o_ctrl.mem_rd  = 1'b1;
            o_ctrl.ir_load = 1'b1;
            o_ctrl.pc_inc  = 1'b1;
         end
         S_E0: begin
            case (i_op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: o_ctrl.mar_load = 1'b1;
               OP_JMP:                         o_ctrl.pc_load  = 1'b1;
               OP_JZ:                          o_ctrl.pc_load  = i_zero_flag;
               OP_OUT:                         o_ctrl.out_load = 1'b1;
               default: ;
            endcase
         end
         S_E1: begin
            case (i_op)
               OP_LDA: begin
                  o_ctrl.mem_rd   = 1'b1;
                  o_ctrl.acc_load = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  o_ctrl.mem_rd = 1'b1;
                  o_ctrl.b_load = 1'b1;
               end
               OP_STA:  o_ctrl.mem_wr = 1'b1;
               default: ;
            endcase
         end
         S_E2: begin
            if (i_op == OP_ADD || i_op == OP_SUB) begin
               o_ctrl.acc_load    = 1'b1;
               o_ctrl.acc_sel_alu = 1'b1;
               o_ctrl.alu_sub     = (i_op == OP_SUB);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: state register,
// opcode latch and retired-instruction counter; strobes come from cpu_ctrl_decode.
module cpu_ctrl_seq
   import cpu_pkg::*;
#(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [OP_W-1:0]  opcode,
   input  logic             zero_flag,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             mar_load,
   output logic             mar_sel_pc,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_load,
   output logic             acc_load,
   output logic             acc_sel_alu,
   output logic             b_load,
   output logic             alu_sub,
   output logic             out_load,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   ctrl_state_e      r_state;
   ctrl_state_e      w_next;
   opcode_e          r_op;
   opcode_e          w_op_in;
   logic             w_retire;
   logic [CNT_W-1:0] r_cnt;
   ctrl_word_t       w_ctrl;

   assign w_op_in = opcode_e'(opcode);

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_IDLE: if (run) w_next = S_F0;
         S_F0:   w_next = S_F1;
         S_F1:   w_next = S_DEC;
         S_DEC: begin
            // Branch on the live opcode; from E0 onward only the latched copy is used.
            case (w_op_in)
               OP_LDA, OP_ADD, OP_SUB, OP_STA,
               OP_JMP, OP_JZ, OP_OUT:   w_next = S_E0;
               OP_HLT:                  w_next = S_HALT;
               default: begin
                  w_next   = S_F0;
                  w_retire = 1'b1;
               end
            endcase
         end
         S_E0: begin
            if (r_op == OP_LDA || r_op == OP_ADD || r_op == OP_SUB || r_op == OP_STA) begin
               w_next = S_E1;
            end else begin
               w_next   = S_F0;
               w_retire = 1'b1;
            end
         end
         S_E1: begin
            if (r_op == OP_ADD || r_op == OP_SUB) begin
               w_next = S_E2;
            end else begin
               w_next   = S_F0;
               w_retire = 1'b1;
            end
         end
         S_E2: begin
            w_next   = S_F0;
            w_retire = 1'b1;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_DEC) r_op <= w_op_in;
   end

   cpu_ctrl_decode u_decode (
      .i_state     (r_state),
      .i_op        (r_op),
      .i_zero_flag (zero_flag),
      .o_ctrl      (w_ctrl)
   );

   assign pc_inc      = w_ctrl.pc_inc;
   assign pc_load     = w_ctrl.pc_load;
   assign mar_load    = w_ctrl.mar_load;
   assign mar_sel_pc  = w_ctrl.mar_sel_pc;
   assign mem_rd      = w_ctrl.mem_rd;
   assign mem_wr      = w_ctrl.mem_wr;
   assign ir_load     = w_ctrl.ir_load;
   assign acc_load    = w_ctrl.acc_load;
   assign acc_sel_alu = w_ctrl.acc_sel_alu;
   assign b_load      = w_ctrl.b_load;
   assign alu_sub     = w_ctrl.alu_sub;
   assign out_load    = w_ctrl.out_load;
   assign halted      = (r_state == S_HALT);
   assign instr_cnt   = r_cnt;

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 8-bit accumulator CPU.
- Generates the one-cycle load, increment and memory strobes that drive the PC, MAR, IR, ACC, B and OUT registers.
- Each of those registers is an 8-bit load register with synchronous reset.
- Sits between the IR opcode field and all datapath enables. It owns fetch/decode/execute timing and halt.

Parameters:
- OP_W, 4, opcode width (upper nibble of IR).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- run  input  1  start request; sampled only in IDLE.
- opcode  input  OP_W  IR[7:4], valid from the cycle after ir_load.
- zero_flag  input  1  ACC==0 flag from datapath.
- pc_inc  output  1  PC += 1 at next edge.
- pc_load  output  1  PC <= IR[3:0] at next edge.
- mar_load  output  1  MAR load strobe.
- mar_sel_pc  output  1  1: MAR source is PC; 0: MAR source is IR[3:0].
- mem_rd  output  1  RAM read enable.
- mem_wr  output  1  RAM write (RAM <= ACC).
- ir_load  output  1  IR <= RAM data.
- acc_load  output  1  ACC load strobe.
- acc_sel_alu  output  1  1: ACC source is ALU; 0: ACC source is RAM.
- b_load  output  1  B <= RAM data.
- alu_sub  output  1  ALU computes ACC-B (else ACC+B).
- out_load  output  1  OUT <= ACC.
- halted  output  1  high while in HALT.
- instr_cnt  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: synchronous, active-high. On the rst edge: state=IDLE, all strobes 0, halted=0, instr_cnt=0. rst overrides everything, including mid-instruction and HALT.
- Strobes are Moore outputs, decoded from the current state (plus zero_flag in E0 only). Each strobe is high for exactly one cycle.
- States: IDLE, F0, F1, DEC, E0, E1, E2, HALT. Every state lasts one clock.
- IDLE: all outputs 0. run=1 -> F0; otherwise stay in IDLE.
- F0: mar_sel_pc=1, mar_load=1 -> F1.
- F1: mem_rd=1, ir_load=1, pc_inc=1 -> DEC.
- DEC: no strobes; branch on opcode.
  - 0 NOP or any undefined opcode: retire -> F0.
  - 15 HLT -> HALT.
  - All other defined opcodes -> E0.
- Execute phases per opcode:
  - LDA (1): E0 mar_load (mar_sel_pc=0). E1 mem_rd, acc_load, acc_sel_alu=0. Retire.
  - ADD (2) / SUB (3): E0 mar_load. E1 mem_rd, b_load. E2 acc_load, acc_sel_alu=1, alu_sub=(op==SUB). Retire.
  - STA (4): E0 mar_load. E1 mem_wr. Retire.
  - JMP (5): E0 pc_load. Retire.
  - JZ (6): E0 pc_load = zero_flag. Retire in both cases.
  - OUT (14): E0 out_load. Retire.
- Retire: the next state is F0, and instr_cnt increments by 1 modulo 2^CNT_W (wraps to 0).
- Total cycles from F0 to the next F0:
  - NOP 3
  - JMP/JZ/OUT 4
  - LDA/STA 5
  - ADD/SUB 6
- HALT:
  - halted=1, all strobes 0.
  - run is ignored; exit only via rst.
  - HLT does not increment instr_cnt.
- The opcode is latched internally in DEC. Changes on the opcode input during E0–E2 have no effect.
- pc_inc and pc_load are never high in the same cycle. mem_rd and mem_wr are never high in the same cycle.

Decomposition:
- cpu_pkg holds:
  - opcode_e enum (NOP, LDA, ADD, SUB, STA, JMP, JZ, OUT, HLT with the values above).
  - ctrl_state_e enum.
  - ctrl_word_t packed struct of all strobe outputs.
  - CTRL_IDLE constant (all zeros).
- One sub-module, cpu_ctrl_decode: purely combinational (state, latched opcode, zero_flag) -> ctrl_word_t.
- cpu_ctrl_seq holds only the state register, opcode latch and counter.

Test Plan:
- rst=1 for 2 cycles, then run=0 for 3 cycles -> state IDLE, every strobe 0, halted=0, instr_cnt=0.
- run=1 pulse, opcode=1 (LDA) -> strobes in order:
  - F0 mar_load + mar_sel_pc
  - F1 mem_rd + ir_load + pc_inc
  - DEC none
  - E0 mar_load with mar_sel_pc=0
  - E1 mem_rd + acc_load
  - then F0 again, instr_cnt=1.
- opcode=3 (SUB) -> E1 b_load; E2 acc_load, acc_sel_alu=1, alu_sub=1; 6-cycle instruction. Same flow with opcode=2 -> alu_sub=0.
- opcode=6 (JZ):
  - zero_flag=1 -> pc_load=1 in E0.
  - zero_flag=0 -> pc_load=0 in E0.
  - Both return to F0 after 4 cycles.
- opcode=15 (HLT) -> halted=1 from the cycle after DEC. Hold run=1 for 10 cycles: stays halted, no strobes, instr_cnt unchanged. Then rst=1 -> IDLE, halted=0, instr_cnt=0.
- Assert rst in E1 of an ADD -> next cycle is IDLE with all strobes 0.
- Separate run with CNT_W=4: 16 NOPs -> instr_cnt wraps to 0.
